param_line_adapter: RTL

- Parametrised line-to-burst adapter between the last-level cache and the burst memory port.
- Converts one LINE_W-bit line transfer into BEATS = LINE_W/BURST_W beats of BURST_W bits, in either direction.
- Latches the request address and line, so the cache needs to hold its request for only one accept cycle.
- Tolerates gaps between memory beats, which the previous fixed 4x64 adapter did not.

---
 rtl/line_adapter_pkg.sv | 26 ++
 rtl/line_beat_counter.sv | 28 ++
 rtl/param_line_adapter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/line_adapter_pkg.sv
// Shared types and elaboration helpers for the line-to-burst adapter.
package line_adapter_pkg;

    // Adapter sequencing states; visible on the top-level debug port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adapter_state_t;

    // Number of memory beats that make up one cache line.
    function automatic int beats_of(input int line_w, input int burst_w);
        return line_w / burst_w;
    endfunction

    // Byte-offset bits inside one cache line.
    function automatic int offs_of(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/line_beat_counter.sv
// Small up-counter with synchronous clear and a terminal-value flag.
// Serves as the line beat index and, with a wider W, as the stall watchdog.
module line_beat_counter #(
    parameter int W     = 2,
    parameter int LIMIT = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         last
);

    // Clear wins over increment; the count wraps naturally at 2**W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign last = (count == W'(LIMIT));

endmodule

// File: rtl/param_line_adapter.sv
// Line-to-burst adapter between the last-level cache and the burst memory port.
// One accepted line request becomes LINE_W/BURST_W memory beats; gaps between
// beats (resp_i low) are tolerated. Optional stall watchdog is compiled in by
// defining LINE_ADAPTER_TIMEOUT_EN.
// Handshake: a request is accepted on the IDLE clock edge where read_i or
// write_i is high; each memory beat transfers on a rising edge where the
// matching strobe is high and resp_i is high; resp_o marks completion for
// exactly one cycle.
module param_line_adapter
    import line_adapter_pkg::*;
#(
    parameter int LINE_W         = 256,
    parameter int BURST_W        = 64,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [LINE_W-1:0]    line_i,
    output logic [LINE_W-1:0]    line_o,
    input  logic [ADDR_W-1:0]    address_i,
    input  logic                 read_i,
    input  logic                 write_i,
    output logic                 resp_o,
    output logic                 err_o,
    input  logic [BURST_W-1:0]   burst_i,
    output logic [BURST_W-1:0]   burst_o,
    output logic [ADDR_W-1:0]    address_o,
    output logic                 read_o,
    output logic                 write_o,
    input  logic                 resp_i,
    output adapter_state_t       state_dbg
);

    localparam int BEATS = beats_of(LINE_W, BURST_W);
    localparam int OFFS  = offs_of(LINE_W);
    localparam int CNT_W = $clog2(BEATS);

    if ((LINE_W % BURST_W) != 0 || !is_pow2(BEATS) || BEATS < 2 || TIMEOUT_CYCLES < 1)
    begin : g_bad_params
        $error("param_line_adapter: LINE_W/BURST_W must be a power of two >= 2");
    end

    adapter_state_t              state;
    logic [ADDR_W-OFFS-1:0]      addr_hi;
    logic [LINE_W-1:0]           line_q;
    logic [LINE_W-1:0]           assembled;
    logic [CNT_W-1:0]            cnt;
    logic                        cnt_last;
    logic                        active;
    logic                        beat;
    logic                        timeout_hit;
    logic                        unused_addr_bits;

    assign active    = (state == READ) || (state == WRITE);
    assign beat      = active && resp_i;
    assign address_o = {addr_hi, {OFFS{1'b0}}};
    assign state_dbg = state;
    assign unused_addr_bits = ^address_i[OFFS-1:0];

    line_beat_counter #(
        .W     (CNT_W),
        .LIMIT (BEATS - 1)
    ) u_beat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (beat),
        .clear   ((state == IDLE) || timeout_hit),
        .count   (cnt),
        .last    (cnt_last)
    );

`ifdef LINE_ADAPTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_count_unused;
    logic            wd_expired;
    logic            err_q;

    // Stall watchdog: restarts on every beat and whenever no transfer is open.
    line_beat_counter #(
        .W     (WD_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (active && !resp_i),
        .clear   (!active || resp_i),
        .count   (wd_count_unused),
        .last    (wd_expired)
    );

    // A beat arriving on the expiry cycle still counts as progress.
    assign timeout_hit = active && wd_expired && !resp_i;

    // Error flag is raised on the same edge that enters DONE after a timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    // Drops the incoming beat into its slot of the line being assembled.
    always_comb begin
        assembled = line_q;
        assembled[int'(cnt)*BURST_W +: BURST_W] = burst_i;
    end

    assign burst_o = (state == WRITE) ? line_q[int'(cnt)*BURST_W +: BURST_W] : '0;

    // Transfer sequencer with registered strobes and completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_hi <= '0;
            line_q  <= '0;
            line_o  <= '0;
            resp_o  <= 1'b0;
            read_o  <= 1'b0;
            write_o <= 1'b0;
        end else begin
            resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_i) begin
                        addr_hi <= address_i[ADDR_W-1:OFFS];
                        read_o  <= 1'b1;
                        state   <= READ;
                    end else if (write_i) begin
                        addr_hi <= address_i[ADDR_W-1:OFFS];
                        line_q  <= line_i;
                        write_o <= 1'b1;
                        state   <= WRITE;
                    end
                end
                READ: begin
                    if (timeout_hit) begin
                        read_o <= 1'b0;
                        resp_o <= 1'b1;
                        state  <= DONE;
                    end else if (resp_i) begin
                        line_q <= assembled;
                        if (cnt_last) begin
                            line_o <= assembled;
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (timeout_hit || (resp_i && cnt_last)) begin
                        write_o <= 1'b0;
                        resp_o  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
